// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: shared state encoding and round-robin pick for latch_bank_arbiter
package latch_bank_pkg;
  localparam int MAX_REQ = 8;
  localparam int PTR_W = 3;

  typedef enum logic {IDLE, WRITE} state_t;

  typedef struct packed {
    logic valid;
    logic [PTR_W-1:0] idx;
  } pick_t;

  function automatic pick_t rrPick(input logic [MAX_REQ-1:0] req, input logic [PTR_W-1:0] ptr, input int numReq);
    pick_t p;
    int i;
    p = '0;
    // Walk offsets from farthest to nearest so the nearest set request wins
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < numReq) begin
        i = (int'(ptr) + k) % numReq;
        if (req[i]) begin
          p.valid = 1'b1;
          p.idx = PTR_W'(i);
        end
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/latch_bank_regs.sv
// latch_bank_regs: register bank with synchronous reset/clear beating write
module latch_bank_regs #(
  parameter int NUM_REGS = 8,
  parameter int WIDTH = 8
) (
  input  logic                        MasterClock,
  input  logic                        rL,
  input  logic                        clrL,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  output logic [NUM_REGS*WIDTH-1:0]   q,
  output logic [NUM_REGS*WIDTH-1:0]   qL
);
  always_ff @(posedge MasterClock) begin
    if (!rL || !clrL) q <= '0;
    else if (we) q[int'(waddr)*WIDTH +: WIDTH] <= wdata;
  end

  assign qL = ~q;
endmodule

// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: round-robin write arbitration into a shared register bank,
// one write per two cycles, with soft clear holding an in-flight write
module latch_bank_arbiter
  import latch_bank_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_REGS = 8,
  parameter int WIDTH = 8
) (
  input  logic                                MasterClock,
  input  logic                                rL,
  input  logic                                clrL,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*$clog2(NUM_REGS)-1:0] addr,
  input  logic [NUM_REQ*WIDTH-1:0]            wdata,
  output logic [NUM_REQ-1:0]                  ack,
  output logic                                busy,
  output logic [NUM_REGS*WIDTH-1:0]           q,
  output logic [NUM_REGS*WIDTH-1:0]           qL
);
  localparam int AW = $clog2(NUM_REGS);

  state_t state, nextState;
  pick_t pick;
  logic [PTR_W-1:0] ptr, win;
  logic [AW-1:0] capAddr;
  logic [WIDTH-1:0] capData;
  logic we;

  always_comb begin
    pick = rrPick(MAX_REQ'(req), ptr, NUM_REQ);
    busy = state == WRITE;
    we = busy && clrL;
    nextState = (state == IDLE && pick.valid) ? WRITE : we ? IDLE : state;
    // A pending reset also hides the ack, since that write is about to be discarded
    ack = (we && rL) ? NUM_REQ'(1) << win : '0;
  end

  always_ff @(posedge MasterClock) begin
    if (!rL) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      capAddr <= '0;
      capData <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && pick.valid) begin
        win <= pick.idx;
        capAddr <= addr[int'(pick.idx)*AW +: AW];
        capData <= wdata[int'(pick.idx)*WIDTH +: WIDTH];
      end
      if (we) ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + PTR_W'(1);
    end
  end

  latch_bank_regs #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH)) bank (
    .MasterClock(MasterClock),
    .rL(rL),
    .clrL(clrL),
    .we(we),
    .waddr(capAddr),
    .wdata(capData),
    .q(q),
    .qL(qL)
  );
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// tb_latch_bank_arbiter: directed scenario tasks with hand-computed expectations
module tb_latch_bank_arbiter;
  logic MasterClock = 1'b0;
  logic rL, clrL;
  logic [3:0] req;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0] ack;
  logic busy;
  logic [63:0] q, qL;
  int checks = 0;
  int failures = 0;

  latch_bank_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .WIDTH(8)) dut (
    .MasterClock(MasterClock),
    .rL(rL),
    .clrL(clrL),
    .req(req),
    .addr(addr),
    .wdata(wdata),
    .ack(ack),
    .busy(busy),
    .q(q),
    .qL(qL)
  );

  always #5 MasterClock = ~MasterClock;

  task automatic tick();
    @(posedge MasterClock);
    #1;
  endtask

  task automatic setReq(input int r, input logic [2:0] a, input logic [7:0] d);
    addr[r*3 +: 3] = a;
    wdata[r*8 +: 8] = d;
  endtask

  task automatic doReset();
    rL = 1'b0;
    req = '0;
    tick();
    tick();
    rL = 1'b1;
  endtask

  task automatic test_reset();
    rL = 1'b0;
    clrL = 1'b1;
    req = 4'b1111;
    addr = '0;
    wdata = '0;
    tick();
    tick();
    tick();
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (q !== 64'h0) begin failures++; $display("FAIL reset_q got=%h exp=0", q); end
    checks++; if (qL !== {64{1'b1}}) begin failures++; $display("FAIL reset_qL got=%h exp=all1", qL); end
    rL = 1'b1;
    tick();
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", ack); end
    req = '0;
    tick();
  endtask

  task automatic test_single_write();
    doReset();
    setReq(2, 3'd3, 8'hA5);
    req = 4'b0100;
    tick();
    checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL single_ack got=%b exp=0100", ack); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (q[31:24] !== 8'h00) begin failures++; $display("FAIL single_early got=%h exp=00", q[31:24]); end
    req = '0;
    tick();
    checks++; if (q[31:24] !== 8'hA5) begin failures++; $display("FAIL single_q3 got=%h exp=a5", q[31:24]); end
    checks++; if (qL[31:24] !== 8'h5A) begin failures++; $display("FAIL single_qL3 got=%h exp=5a", qL[31:24]); end
    checks++; if (ack !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL single_idle ack=%b busy=%b exp=0000/0", ack, busy); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    doReset();
    for (int r = 0; r < 4; r++) setReq(r, 3'(r), 8'h10 + 8'(r));
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = (i % 2 == 0) ? 4'b0001 << (i / 2) : 4'b0000;
      checks++; if (ack !== exp) begin failures++; $display("FAIL fair_ack cycle=%0d got=%b exp=%b", i, ack, exp); end
    end
    tick();
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL fair_wrap got=%b exp=0001", ack); end
    req = '0;
    tick();
    checks++; if (q[31:0] !== 32'h13121110) begin failures++; $display("FAIL fair_data got=%h exp=13121110", q[31:0]); end
  endtask

  task automatic test_clear_collision();
    doReset();
    setReq(0, 3'd2, 8'h77);
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    checks++; if (q[23:16] !== 8'h77) begin failures++; $display("FAIL clr_pre got=%h exp=77", q[23:16]); end
    setReq(1, 3'd5, 8'h3C);
    req = 4'b0010;
    tick();
    clrL = 1'b0;
    req = '0;
    #1;
    checks++; if (ack !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL clr_suppress ack=%b busy=%b exp=0000/1", ack, busy); end
    tick();
    checks++; if (q !== 64'h0) begin failures++; $display("FAIL clr_bank got=%h exp=0", q); end
    checks++; if (busy !== 1'b1 || ack !== 4'b0000) begin failures++; $display("FAIL clr_hold ack=%b busy=%b exp=0000/1", ack, busy); end
    clrL = 1'b1;
    #1;
    checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL clr_release_ack got=%b exp=0010", ack); end
    tick();
    checks++; if (q !== 64'h0000_3C00_0000_0000) begin failures++; $display("FAIL clr_land got=%h exp=00003c0000000000", q); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_write();
    doReset();
    setReq(2, 3'd4, 8'h99);
    req = 4'b0100;
    tick();
    rL = 1'b0;
    req = '0;
    #1;
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rmid_ack got=%b exp=0000", ack); end
    tick();
    checks++; if (q !== 64'h0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_abort q=%h busy=%b exp=0/0", q, busy); end
    rL = 1'b1;
    req = 4'b1111;
    tick();
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL rmid_ptr got=%b exp=0001", ack); end
    req = '0;
    tick();
  endtask

  task automatic test_stability();
    doReset();
    setReq(3, 3'd6, 8'hC3);
    req = 4'b1000;
    tick();
    setReq(3, 3'd1, 8'hFF);
    req = '0;
    checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL stab_ack got=%b exp=1000", ack); end
    tick();
    checks++; if (q[55:48] !== 8'hC3) begin failures++; $display("FAIL stab_q6 got=%h exp=c3", q[55:48]); end
    checks++; if (q[15:8] !== 8'h00) begin failures++; $display("FAIL stab_q1 got=%h exp=00", q[15:8]); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_clear_collision();
    test_reset_mid_write();
    test_stability();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
